// File: rtl/sub4_serial_if.sv
// Request/result bundle for the bit-serial 4-bit subtractor.
// The master drives the operands and start; the slave returns status and result.
interface sub4_serial_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       b4;

    modport master (output start, A, B, input busy, done, diff, b4);
    modport slave  (input start, A, B, output busy, done, diff, b4);
endinterface

// File: rtl/sub4_serial.sv
// Bit-serial 4-bit unsigned subtractor: A-B one bit per clock, LSB first,
// through a registered borrow; done pulses for one cycle with diff and b4.
module sub4_serial (
    input  logic          clk,
    input  logic          rst_n,
    sub4_serial_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_ra;
    logic [3:0] r_rb;
    logic [3:0] r_rd;
    logic [1:0] r_cnt;
    logic       r_br;
    logic       r_b4;

    logic       w_d;
    logic       w_br_next;
    logic       w_accept;
    logic       w_last;

    always_comb begin
        w_d       = r_ra[0] ^ r_rb[0] ^ r_br;
        w_br_next = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
        w_accept  = (r_state == S_IDLE) && bus.start;
        w_last    = (r_state == S_RUN) && (r_cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == 2'd3) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The working borrow is cleared on accept, so the reported borrow lives in
    // its own register captured on the final bit and held across the next run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
            r_b4  <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= bus.A;
            r_rb  <= bus.B;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_rd  <= {w_d, r_rd[3:1]};
            r_ra  <= {1'b0, r_ra[3:1]};
            r_rb  <= {1'b0, r_rb[3:1]};
            r_br  <= w_br_next;
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
                r_b4 <= w_br_next;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.diff = r_rd;
    assign bus.b4   = r_b4;

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial: directed and randomized operations
// compared against plain-arithmetic expectations for A-B and A<B.
module tb_sub4_serial;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sub4_serial_if bus ();

    sub4_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_diff(input logic [3:0] a, input logic [3:0] b);
        int v;
        v = (int'(a) - int'(b) + 16) % 16;
        return v[3:0];
    endfunction

    function automatic logic ref_borrow(input logic [3:0] a, input logic [3:0] b);
        return (int'(a) < int'(b));
    endfunction

    // Stimulus only: issues one start and waits (bounded) for done.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int busy_cycles,
                         output logic [3:0] d, output logic bo, output logic got);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 4'($urandom);
        bus.B     = 4'($urandom);
        lat = 1;
        busy_cycles = 0;
        got = 1'b0;
        d = '0;
        bo = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                got = 1'b1;
                d   = bus.diff;
                bo  = bus.b4;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.A = 4'($urandom);
        bus.B = 4'($urandom);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.b4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h b4=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.b4);
        end
        for (int i = 0; i < 10; i++) begin
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.diff, bus.b4} !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: busy=%b done=%b diff=%h b4=%b, required all 0",
                         i, bus.busy, bus.done, bus.diff, bus.b4);
            end
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        logic [3:0] d;
        logic bo, got;
        do_op(4'd9, 4'd3, lat, bc, d, bo, got);
        checks++;
        if (got !== 1'b1 || lat != 5) begin
            errors++;
            $display("FAIL basic_latency: got=%b latency=%0d, required done at cycle 5", got, lat);
        end
        checks++;
        if (bc != 4) begin
            errors++;
            $display("FAIL basic_busy: busy cycles=%0d, required 4", bc);
        end
        checks++;
        if (d !== 4'd6 || bo !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: diff=%h b4=%b, required diff=6 b4=0", d, bo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== 4'd6 || bus.b4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: done=%b busy=%b diff=%h b4=%b, required 0 0 6 0",
                     bus.done, bus.busy, bus.diff, bus.b4);
        end
    endtask

    task automatic test_borrow;
        logic [3:0] ta [4] = '{4'd3, 4'd0, 4'd0, 4'hF};
        logic [3:0] tb [4] = '{4'd9, 4'd1, 4'd0, 4'hF};
        logic [3:0] ed [4] = '{4'hA, 4'hF, 4'h0, 4'h0};
        logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat, bc;
        logic [3:0] d;
        logic bo, got;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], lat, bc, d, bo, got);
            checks++;
            if (got !== 1'b1 || d !== ed[i] || bo !== eb[i]) begin
                errors++;
                $display("FAIL borrow A=%h B=%h: got=%b diff=%h b4=%b, required diff=%h b4=%b",
                         ta[i], tb[i], got, d, bo, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int ndone, nbusy;
        logic [3:0] d;
        logic bo;
        int lat, bc;
        logic got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 4'd5;
        bus.B = 4'd2;
        ndone = 0;
        nbusy = 0;
        d = '0;
        bo = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.start = (c == 2 || c == 5);
            bus.A = (c == 2 || c == 5) ? 4'd1 : 4'($urandom);
            bus.B = (c == 2 || c == 5) ? 4'd7 : 4'($urandom);
            if (bus.done) begin
                ndone++;
                d = bus.diff;
                bo = bus.b4;
                checks++;
                if (c != 5) begin
                    errors++;
                    $display("FAIL ignored_done_cycle: done in cycle %0d, required cycle 5", c);
                end
            end
            if (c >= 6 && bus.busy) nbusy++;
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 1 || d !== 4'd3 || bo !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: done pulses=%0d diff=%h b4=%b, required 1 pulse diff=3 b4=0",
                     ndone, d, bo);
        end
        checks++;
        if (nbusy != 0) begin
            errors++;
            $display("FAIL ignored_queued: busy cycles after done=%0d, required 0", nbusy);
        end
        do_op(4'd1, 4'd7, lat, bc, d, bo, got);
        checks++;
        if (got !== 1'b1 || d !== 4'hA || bo !== 1'b1) begin
            errors++;
            $display("FAIL ignored_next: got=%b diff=%h b4=%b, required diff=a b4=1", got, d, bo);
        end
    endtask

    task automatic test_reset_mid;
        int ndone, lat, bc;
        logic [3:0] d;
        logic bo, got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 4'hC;
        bus.B = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.b4} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b diff=%h b4=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.b4);
        end
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL midreset_abort: done/busy cycles=%0d, required 0", ndone);
        end
        do_op(4'hC, 4'd4, lat, bc, d, bo, got);
        checks++;
        if (got !== 1'b1 || d !== 4'd8 || bo !== 1'b0 || lat != 5) begin
            errors++;
            $display("FAIL midreset_fresh: got=%b diff=%h b4=%b latency=%0d, required diff=8 b4=0 latency=5",
                     got, d, bo, lat);
        end
    endtask

    task automatic test_exhaustive;
        int lat, bc;
        logic [3:0] d;
        logic bo, got;
        logic [4:0] sum;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a, b;
            a = 4'(i >> 4);
            b = 4'(i);
            do_op(a, b, lat, bc, d, bo, got);
            checks++;
            if (got !== 1'b1 || lat != 5 || d !== ref_diff(a, b) || bo !== ref_borrow(a, b)) begin
                errors++;
                $display("FAIL exhaustive A=%h B=%h: got=%b lat=%0d diff=%h b4=%b, required lat=5 diff=%h b4=%b",
                         a, b, got, lat, d, bo, ref_diff(a, b), ref_borrow(a, b));
            end
            sum = {1'b0, d} + {1'b0, b} + 5'd0;
            checks++;
            if (sum[3:0] !== a) begin
                errors++;
                $display("FAIL adder_xcheck A=%h B=%h: diff+B=%h, required %h", a, b, sum[3:0], a);
            end
        end
    endtask

    task automatic test_random_gaps;
        int lat, bc;
        logic [3:0] a, b, d;
        logic bo, got;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.A = 4'($urandom);
                bus.B = 4'($urandom);
            end
            do_op(a, b, lat, bc, d, bo, got);
            checks++;
            if (got !== 1'b1 || bc != 4 || d !== ref_diff(a, b) || bo !== ref_borrow(a, b)) begin
                errors++;
                $display("FAIL random A=%h B=%h: got=%b busy=%0d diff=%h b4=%b, required busy=4 diff=%h b4=%b",
                         a, b, got, bc, d, bo, ref_diff(a, b), ref_borrow(a, b));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignored_start();
        test_reset_mid();
        test_exhaustive();
        test_random_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
